// File: rtl/adres_pe_param.sv
// rtl/adres_pe_param.sv - ADRES-style CGRA processing element with serial configuration chain
//
// Purpose: one PE of a coarse-grained array. A serial scan chain (cfg) holds the
// opcode, operand selects, output select, register-file controls and a constant.
// Operands come from neighbour inputs, the constant or the local register file.
// The ALU result is registered in alu_reg and optionally written into the RF.
//
// Ports:
//   CGRA_Clock     in   clock for datapath and configuration chain
//   CGRA_Reset     in   asynchronous active-high reset
//   Config_Enable  in   1 = shift cfg this cycle, datapath frozen
//   ConfigIn       in   serial configuration bit in
//   ConfigOut      out  serial configuration bit out (cfg MSB)
//   in_flat        in   NUM_IN neighbour operands, inK = in_flat[K*WIDTH +: WIDTH]
//   out            out  alu_reg or rf[rf_raddr], chosen by out_sel
//   out_valid      out  1 once alu_reg holds a computed result
module adres_pe_param #(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 8,
  parameter int RF_DEPTH = 4
) (
  input  logic                    CGRA_Clock,
  input  logic                    CGRA_Reset,
  input  logic                    Config_Enable,
  input  logic                    ConfigIn,
  output logic                    ConfigOut,
  input  logic [NUM_IN*WIDTH-1:0] in_flat,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid
);

  localparam int SA       = $clog2(NUM_IN + 2);
  localparam int SB       = $clog2(NUM_IN + 1);
  localparam int RA       = $clog2(RF_DEPTH);
  localparam int SH       = $clog2(WIDTH);
  localparam int CFG_BITS = 3 + SA + SB + 1 + 1 + 2 * RA + WIDTH;

  // Field LSB positions inside cfg; const occupies the bottom WIDTH bits.
  localparam int P_RADDR = WIDTH;
  localparam int P_WADDR = P_RADDR + RA;
  localparam int P_WE    = P_WADDR + RA;
  localparam int P_OSEL  = P_WE + 1;
  localparam int P_SELB  = P_OSEL + 1;
  localparam int P_SELA  = P_SELB + SB;
  localparam int P_OP    = P_SELA + SA;

  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [WIDTH-1:0]    alu_q, alu_d;
  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    rf_q [RF_DEPTH];

  logic [2:0]       op;
  logic [SA-1:0]    sel_a;
  logic [SB-1:0]    sel_b;
  logic             out_sel;
  logic             rf_we;
  logic [RA-1:0]    rf_waddr;
  logic [RA-1:0]    rf_raddr;
  logic [WIDTH-1:0] cfg_const;

  assign op        = cfg_q[P_OP +: 3];
  assign sel_a     = cfg_q[P_SELA +: SA];
  assign sel_b     = cfg_q[P_SELB +: SB];
  assign out_sel   = cfg_q[P_OSEL];
  assign rf_we     = cfg_q[P_WE];
  assign rf_waddr  = cfg_q[P_WADDR +: RA];
  assign rf_raddr  = cfg_q[P_RADDR +: RA];
  assign cfg_const = cfg_q[WIDTH-1:0];

  logic [WIDTH-1:0] rf_rdata;
  logic [WIDTH-1:0] opa, opb, alu_res;
  logic             rf_wr;

  // Read sees the pre-write contents; a same-cycle write lands at the clock edge.
  assign rf_rdata = rf_q[rf_raddr];

  always_comb begin
    opa = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_a == SA'(k)) opa = in_flat[k*WIDTH +: WIDTH];
    end
    if (sel_a == SA'(NUM_IN))     opa = cfg_const;
    if (sel_a == SA'(NUM_IN + 1)) opa = rf_rdata;
  end

  always_comb begin
    opb = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_b == SB'(k)) opb = in_flat[k*WIDTH +: WIDTH];
    end
    if (sel_b == SB'(NUM_IN)) opb = cfg_const;
  end

  // Shift amounts use only the low log2(WIDTH) bits of B.
  always_comb begin
    alu_res = '0;
    case (op)
      3'd0:    alu_res = opa + opb;
      3'd1:    alu_res = opa - opb;
      3'd2:    alu_res = opa * opb;
      3'd3:    alu_res = opa & opb;
      3'd4:    alu_res = opa | opb;
      3'd5:    alu_res = opa ^ opb;
      3'd6:    alu_res = opa << opb[SH-1:0];
      default: alu_res = opa >> opb[SH-1:0];
    endcase
  end

  always_comb begin
    cfg_d   = cfg_q;
    alu_d   = alu_q;
    valid_d = valid_q;
    rf_wr   = 1'b0;
    if (Config_Enable) begin
      cfg_d = {cfg_q[CFG_BITS-2:0], ConfigIn};
    end else begin
      alu_d   = alu_res;
      valid_d = 1'b1;
      rf_wr   = rf_we;
    end
  end

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      cfg_q   <= '0;
      alu_q   <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < RF_DEPTH; k++) rf_q[k] <= '0;
    end else begin
      cfg_q   <= cfg_d;
      alu_q   <= alu_d;
      valid_q <= valid_d;
      if (rf_wr) rf_q[rf_waddr] <= alu_res;
    end
  end

  assign out       = out_sel ? rf_rdata : alu_q;
  assign out_valid = valid_q;
  assign ConfigOut = cfg_q[CFG_BITS-1];

endmodule

// File: tb/tb_adres_pe_param.sv
// tb/tb_adres_pe_param.sv - self-checking bench for adres_pe_param (default parameters)
module tb_adres_pe_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_en;
  logic         cfg_in;
  logic         cfg_out;
  logic [255:0] in_flat;
  logic [31:0]  out;
  logic         out_valid;

  logic [31:0]  in_arr [8];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  logic [48:0]  m_cfg;
  logic [31:0]  m_alu;
  logic [31:0]  m_rf [4];
  logic         m_valid;

  always #5 clk = ~clk;

  always_comb begin
    in_flat = '0;
    for (int k = 0; k < 8; k++) in_flat[k*32 +: 32] = in_arr[k];
  end

  adres_pe_param dut (
    .CGRA_Clock   (clk),
    .CGRA_Reset   (rst),
    .Config_Enable(cfg_en),
    .ConfigIn     (cfg_in),
    .ConfigOut    (cfg_out),
    .in_flat      (in_flat),
    .out          (out),
    .out_valid    (out_valid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Configuration word built arithmetically from its fields (MSB first: op, sel_a, sel_b, out_sel, rf_we, waddr, raddr, const).
  function automatic logic [48:0] mk(input int op, input int sa, input int sb, input int osel,
                                     input int we, input int wa, input int ra, input logic [31:0] c);
    logic [48:0] v;
    v = 49'(op);
    v = v * 16 + 49'(sa);
    v = v * 16 + 49'(sb);
    v = v * 2 + 49'(osel);
    v = v * 2 + 49'(we);
    v = v * 4 + 49'(wa);
    v = v * 4 + 49'(ra);
    v = v * 49'h1_0000_0000 + 49'(c);
    return v;
  endfunction

  function automatic int fld(input int lsb, input int nbits);
    return int'((m_cfg / (49'd1 << lsb)) % (49'd1 << nbits));
  endfunction

  function automatic logic [31:0] m_out();
    if (fld(37, 1) == 1) return m_rf[fld(32, 2)];
    return m_alu;
  endfunction

  function automatic logic [31:0] m_res();
    int op, sa, sb;
    logic [31:0] a, b, c;
    op = fld(46, 3); sa = fld(42, 4); sb = fld(38, 4);
    c  = m_cfg[31:0];
    if (sa < 8) a = in_arr[sa];
    else if (sa == 8) a = c;
    else if (sa == 9) a = m_rf[fld(32, 2)];
    else a = 0;
    if (sb < 8) b = in_arr[sb];
    else if (sb == 8) b = c;
    else b = 0;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return 32'((64'(a) * 64'(b)) % 64'h1_0000_0000);
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("out", 64'(out), 64'(m_out()));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("ConfigOut", 64'(cfg_out), 64'(m_cfg[48]));
    end
  end

  task automatic model_clear();
    m_cfg = '0; m_alu = '0; m_valid = 1'b0;
    for (int k = 0; k < 4; k++) m_rf[k] = '0;
  endtask

  task automatic tick();
    logic [31:0] res;
    logic        bit_in;
    res    = m_res();
    bit_in = cfg_in;
    @(posedge clk);
    if (cfg_en) begin
      m_cfg = {m_cfg[47:0], bit_in};
    end else begin
      if (fld(36, 1) == 1) m_rf[fld(34, 2)] = res;
      m_alu   = res;
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic load(input logic [48:0] v);
    cfg_en = 1'b1;
    for (int i = 48; i >= 0; i--) begin
      cfg_in = v[i];
      tick();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  logic [48:0] cfg_a, pat;

  initial begin
    rst    = 1'b1;
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    for (int k = 0; k < 8; k++) in_arr[k] = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_out", 64'(out), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_cfgout", 64'(cfg_out), 64'd0);
    chk_en = 1'b1;
    #1 rst = 1'b0;

    // add in0 + in1
    cfg_a = mk(0, 0, 1, 0, 0, 0, 0, 32'd0);
    in_arr[0] = 32'd5; in_arr[1] = 32'd7;
    load(cfg_a);
    check("valid_before_run", 64'(out_valid), 64'd0);
    tick();
    check("add_5_7", 64'(out), 64'd12);
    check("valid_after_run", 64'(out_valid), 64'd1);

    // chain echo: load pattern, then shifting a new word must expose it MSB first
    pat = 49'h1_5A5A_C3C3_0F0F;
    load(pat);
    cfg_en = 1'b1;
    for (int i = 48; i >= 0; i--) begin
      check("echo_bit", 64'(cfg_out), 64'(pat[i]));
      cfg_in = cfg_a[i];
      tick();
    end
    cfg_en = 1'b0;
    check("alu_held_over_config", 64'(out), 64'd12);

    // sub with wrap
    do_reset();
    in_arr[2] = 32'd1;
    load(mk(1, 2, 8, 0, 0, 0, 0, 32'd3));
    tick();
    check("sub_wrap", 64'(out), 64'hFFFF_FFFE);

    // reset mid-shift
    cfg_en = 1'b1;
    for (int i = 48; i > 28; i--) begin
      cfg_in = cfg_a[i];
      tick();
    end
    rst = 1'b1;
    model_clear();
    #1;
    check("midreset_out", 64'(out), 64'd0);
    check("midreset_valid", 64'(out_valid), 64'd0);
    check("midreset_cfgout", 64'(cfg_out), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    cfg_en = 1'b0;
    in_arr[0] = 32'd5; in_arr[1] = 32'd7;
    load(cfg_a);
    tick();
    check("reload_after_reset", 64'(out), 64'd12);

    // accumulate into rf[0]: A = rf[0], B = const 1, out shows rf[0]
    do_reset();
    load(mk(0, 9, 8, 1, 1, 0, 0, 32'd1));
    check("acc_first_read", 64'(out), 64'd0);
    tick();
    check("acc_1", 64'(out), 64'd1);
    repeat (4) tick();
    check("acc_5", 64'(out), 64'd5);

    // shift amount masked to 5 bits
    do_reset();
    in_arr[0] = 32'd33;
    load(mk(6, 8, 0, 0, 0, 0, 0, 32'd1));
    tick();
    check("shl_mask", 64'(out), 64'd2);

    // multiply keeps low bits only
    in_arr[0] = 32'h1_0000; in_arr[1] = 32'h1_0000;
    load(mk(2, 0, 1, 0, 0, 0, 0, 32'd0));
    tick();
    check("mul_low", 64'(out), 64'd0);

    // logical shift right by const
    in_arr[0] = 32'h8000_0080;
    load(mk(7, 0, 8, 0, 0, 0, 0, 32'd4));
    tick();
    check("shr", 64'(out), 64'h0800_0008);

    // every opcode with varied operands; rf port exercised on a separate entry
    for (int op = 0; op < 8; op++) begin
      load(mk(op, op % 8, (op + 3) % 8, op % 2, 1, 2, (op % 2) * 2, 32'd0));
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 8; k++) in_arr[k] = $urandom;
        tick();
      end
    end

    // out-of-range selects give zero operands
    in_arr[0] = 32'd9;
    load(mk(4, 12, 11, 0, 0, 0, 0, 32'hABCD));
    tick();
    check("unused_selects_zero", 64'(out), 64'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
